// File: rtl/weight_stream_reader.sv
// Streams DEPTH weights from a falling-edge-read BRAM to the MAC through a 2-entry skid buffer.
// Optional IDLE-time BRAM load port: define WEIGHT_STREAM_LOAD_EN.
module weight_stream_reader #(
  parameter int DEPTH  = 28,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic              BRAM_EN,
  output logic              BRAM_WE,
  output logic [DATA_W-1:0] BRAM_DI,
  input  logic [DATA_W-1:0] BRAM_DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST,
  output logic [ADDR_W-1:0] W_INDEX
`ifdef WEIGHT_STREAM_LOAD_EN
  ,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  input  logic              LD_LAST,
  output logic              LD_READY
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  state_t            state;
  logic [DATA_W-1:0] buf_data [2];
  logic [ADDR_W-1:0] buf_idx  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              inflight;
  logic [1:0]        count;
  logic [ADDR_W:0]   issued;
  logic [2:0]        occ;
  logic              pop;
  logic              issue;

  assign W_VALID = (count != 2'd0);
  assign W_DATA  = buf_data[rd_ptr];
  assign W_INDEX = buf_idx[rd_ptr];
  assign W_LAST  = W_VALID && (buf_idx[rd_ptr] == LAST_IDX);

  // Credit: a read may only be issued if its word is guaranteed a buffer slot next edge.
  always_comb begin
    pop   = W_VALID & W_READY;
    occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    issue = (state == S_FETCH) && (issued < DEPTH_C) && (occ < 3'd2);
  end

`ifdef WEIGHT_STREAM_LOAD_EN
  logic [ADDR_W-1:0] ld_ptr;
  assign LD_READY = (state == S_IDLE);
`else
  assign BRAM_WE = 1'b0;
  assign BRAM_DI = '0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      BRAM_ADDR <= '0;
      BRAM_EN   <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= '0;
      inflight  <= 1'b0;
      issued    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_idx[i]  <= '0;
      end
`ifdef WEIGHT_STREAM_LOAD_EN
      BRAM_WE <= 1'b0;
      BRAM_DI <= '0;
      ld_ptr  <= '0;
`endif
    end else begin
      DONE     <= 1'b0;
      inflight <= issue;
      // BRAM_ADDR still holds the address of the in-flight read at this edge.
      if (inflight) begin
        buf_data[wr_ptr] <= BRAM_DO;
        buf_idx[wr_ptr]  <= BRAM_ADDR;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};

      case (state)
        S_IDLE: begin
          BRAM_EN <= 1'b0;
`ifdef WEIGHT_STREAM_LOAD_EN
          BRAM_WE <= 1'b0;
`endif
          if (START) begin
            state     <= S_FETCH;
            BUSY      <= 1'b1;
            BRAM_ADDR <= '0;
            BRAM_EN   <= 1'b1;
            issued    <= (ADDR_W+1)'(1);
            inflight  <= 1'b1;
          end
`ifdef WEIGHT_STREAM_LOAD_EN
          else if (LD_VALID) begin
            BRAM_EN   <= 1'b1;
            BRAM_WE   <= 1'b1;
            BRAM_DI   <= LD_DATA;
            BRAM_ADDR <= ld_ptr;
            ld_ptr    <= (LD_LAST || ld_ptr == LAST_IDX) ? '0 : ld_ptr + 1'b1;
          end
`endif
        end
        S_FETCH, S_DRAIN: begin
          if (issue) begin
            BRAM_EN   <= 1'b1;
            BRAM_ADDR <= issued[ADDR_W-1:0];
            issued    <= issued + 1'b1;
            if (issued == DEPTH_C - 1'b1) state <= S_DRAIN;
          end else begin
            // Stalled: park the address on the next word, clamped at the last entry.
            BRAM_EN <= 1'b0;
            if (issued < DEPTH_C) BRAM_ADDR <= issued[ADDR_W-1:0];
          end
          if (pop && W_LAST) begin
            state <= S_DONE;
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_reader.sv
// Self-checking bench for weight_stream_reader with a falling-edge BRAM model.
module tb_weight_stream_reader;
  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              START = 1'b0;
  logic              W_READY = 1'b0;
  logic              BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST;
  logic [ADDR_W-1:0] BRAM_ADDR, W_INDEX;
  logic [DATA_W-1:0] BRAM_DI, W_DATA;
  logic [DATA_W-1:0] bram_do = '0;
  logic [DATA_W-1:0] mem   [32];
  logic [DATA_W-1:0] ref_w [DEPTH];
`ifdef WEIGHT_STREAM_LOAD_EN
  logic              LD_VALID = 1'b0;
  logic [DATA_W-1:0] LD_DATA = '0;
  logic              LD_LAST = 1'b0;
  logic              LD_READY;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (BRAM_EN) begin
      if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
      else         bram_do <= mem[BRAM_ADDR];
    end
  end

  weight_stream_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_DI(BRAM_DI),
    .BRAM_DO(bram_do), .W_DATA(W_DATA), .W_VALID(W_VALID), .W_READY(W_READY),
    .W_LAST(W_LAST), .W_INDEX(W_INDEX)
`ifdef WEIGHT_STREAM_LOAD_EN
    , .LD_VALID(LD_VALID), .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_READY(LD_READY)
`endif
  );

  task automatic preload_ramp(input int base);
    for (int i = 0; i < 32; i++) mem[i] = (i < DEPTH) ? DATA_W'(base + i) : '0;
    for (int i = 0; i < DEPTH; i++) ref_w[i] = DATA_W'(base + i);
  endtask

  task automatic preload_random();
    for (int i = 0; i < 32; i++) mem[i] = DATA_W'($urandom);
    for (int i = 0; i < DEPTH; i++) ref_w[i] = mem[i];
  endtask

  // Leaves the caller 1 time unit after the edge that accepted START.
  task automatic start_pulse();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    total++;
    if ({BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b expected 000000", {BUSY, DONE, BRAM_EN, BRAM_WE, W_VALID, W_LAST});
    end
    total++;
    if ({BRAM_ADDR, W_INDEX, W_DATA, BRAM_DI} !== '0) begin
      bad++; $display("FAIL reset_buses: got addr=%0d idx=%0d data=%h di=%h expected all 0", BRAM_ADDR, W_INDEX, W_DATA, BRAM_DI);
    end
    RST = 1'b0;
  endtask

  task automatic test_full_rate();
    preload_ramp(16'h0100);
    W_READY = 1'b1;
    start_pulse();
    @(negedge CLK);
    total++;
    if ({BUSY, BRAM_EN, BRAM_ADDR, W_VALID} !== {1'b1, 1'b1, ADDR_W'(0), 1'b0}) begin
      bad++; $display("FAIL accept_cycle: got busy=%b en=%b addr=%0d valid=%b expected 1 1 0 0", BUSY, BRAM_EN, BRAM_ADDR, W_VALID);
    end
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge CLK);
      total++;
      if ({W_VALID, W_DATA, W_INDEX, W_LAST, DONE, BRAM_WE} !==
          {1'b1, ref_w[k], ADDR_W'(k), (k == DEPTH-1), 1'b0, 1'b0}) begin
        bad++; $display("FAIL full_rate_word%0d: got v=%b d=%h i=%0d l=%b done=%b we=%b expected v=1 d=%h i=%0d l=%b done=0 we=0",
                        k, W_VALID, W_DATA, W_INDEX, W_LAST, DONE, BRAM_WE, ref_w[k], k, (k == DEPTH-1));
      end
    end
    @(negedge CLK);
    total++;
    if ({DONE, BUSY, W_VALID} !== 3'b100) begin
      bad++; $display("FAIL done_pulse: got done=%b busy=%b valid=%b expected 1 0 0", DONE, BUSY, W_VALID);
    end
    @(negedge CLK);
    total++;
    if (DONE !== 1'b0) begin
      bad++; $display("FAIL done_one_cycle: got %b expected 0", DONE);
    end
  endtask

  task automatic test_random_ready(input bit rand_data);
    int k = 0;
    int dones = 0;
    bit fin = 0;
    if (rand_data) preload_random(); else preload_ramp(16'h0100);
    start_pulse();
    for (int c = 0; c < 400 && !fin; c++) begin
      W_READY = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (DONE) begin dones++; fin = 1; end
      if (W_VALID && W_READY) begin
        total++;
        if (k >= DEPTH) begin
          bad++; $display("FAIL rand_extra_word: got handshake %0d expected at most %0d", k, DEPTH);
        end else if ({W_DATA, W_INDEX, W_LAST} !== {ref_w[k], ADDR_W'(k), (k == DEPTH-1)}) begin
          bad++; $display("FAIL rand_word%0d: got d=%h i=%0d l=%b expected d=%h i=%0d l=%b",
                          k, W_DATA, W_INDEX, W_LAST, ref_w[k], k, (k == DEPTH-1));
        end
        k++;
      end
      @(posedge CLK); #1;
    end
    total++;
    if (k != DEPTH || dones != 1) begin
      bad++; $display("FAIL rand_count: got words=%0d dones=%0d expected %0d 1", k, dones, DEPTH);
    end
    W_READY = 1'b1;
  endtask

  task automatic test_backpressure();
    int k = 0;
    int stall = 0;
    int cyc = 0;
    bit trig = 0;
    bit fin = 0;
    preload_ramp(16'h0100);
    W_READY = 1'b1;
    start_pulse();
    for (int c = 0; c < 200 && !fin; c++) begin
      if (!trig && W_VALID && W_INDEX == ADDR_W'(3)) begin trig = 1; stall = 10; end
      W_READY = (stall == 0);
      @(negedge CLK);
      cyc++;
      if (stall > 0) begin
        if (stall <= 9) begin
          total++;
          if ({BRAM_EN, BRAM_ADDR, W_VALID, W_INDEX, W_DATA} !== {1'b0, ADDR_W'(5), 1'b1, ADDR_W'(3), ref_w[3]}) begin
            bad++; $display("FAIL stall_hold: got en=%b addr=%0d v=%b i=%0d d=%h expected 0 5 1 3 %h",
                            BRAM_EN, BRAM_ADDR, W_VALID, W_INDEX, W_DATA, ref_w[3]);
          end
        end
        stall--;
      end else if (W_VALID && W_READY) begin
        total++;
        if (k >= DEPTH || {W_DATA, W_INDEX} !== {ref_w[k], ADDR_W'(k)}) begin
          bad++; $display("FAIL bp_word%0d: got d=%h i=%0d expected in-order word %0d", k, W_DATA, W_INDEX, k);
        end
        k++;
      end
      if (DONE) fin = 1;
      @(posedge CLK); #1;
    end
    total++;
    if (!fin || k != DEPTH || cyc != 40) begin
      bad++; $display("FAIL bp_timing: got done=%b words=%0d done_cycle=%0d expected 1 %0d 40", fin, k, cyc, DEPTH);
    end
    W_READY = 1'b1;
  endtask

  task automatic test_start_ignored();
    int k = 0;
    int dones = 0;
    bit fin = 0;
    preload_ramp(16'h0100);
    W_READY = 1'b1;
    start_pulse();
    for (int c = 0; c < 100 && !fin; c++) begin
      START = (W_VALID && W_INDEX == ADDR_W'(10)) || DONE;
      @(negedge CLK);
      if (DONE) begin dones++; fin = 1; end
      if (W_VALID) begin
        total++;
        if (k >= DEPTH || W_DATA !== ref_w[k]) begin
          bad++; $display("FAIL restart_word%0d: got %h expected in-order word %0d", k, W_DATA, k);
        end
        k++;
      end
      @(posedge CLK); #1;
    end
    START = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      if (DONE) dones++;
      total++;
      if ({BUSY, BRAM_EN, W_VALID} !== 3'b000) begin
        bad++; $display("FAIL start_in_done: got busy=%b en=%b valid=%b expected 0 0 0", BUSY, BRAM_EN, W_VALID);
      end
    end
    total++;
    if (k != DEPTH || dones != 1) begin
      bad++; $display("FAIL restart_count: got words=%0d dones=%0d expected %0d 1", k, dones, DEPTH);
    end
  endtask

  task automatic test_reset_midstream();
    bit hit = 0;
    preload_random();
    W_READY = 1'b1;
    start_pulse();
    for (int c = 0; c < 60 && !hit; c++) begin
      if (W_VALID && W_INDEX == ADDR_W'(13)) hit = 1;
      else begin @(posedge CLK); #1; end
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL reach_index13: got not reached expected reached");
    end
    RST = 1'b1;
    #1;
    total++;
    if ({BUSY, DONE, BRAM_EN, W_VALID, W_LAST, BRAM_ADDR, W_INDEX, W_DATA} !== '0) begin
      bad++; $display("FAIL async_reset: got busy=%b en=%b v=%b addr=%0d i=%0d d=%h expected all 0",
                      BUSY, BRAM_EN, W_VALID, BRAM_ADDR, W_INDEX, W_DATA);
    end
    @(negedge CLK);
    RST = 1'b0;
    test_random_ready(1'b0);
  endtask

`ifdef WEIGHT_STREAM_LOAD_EN
  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) ref_w[i] = DATA_W'(16'hA000 + i);
    @(negedge CLK);
    total++;
    if (LD_READY !== 1'b1) begin
      bad++; $display("FAIL ld_ready_idle: got %b expected 1", LD_READY);
    end
    @(posedge CLK); #1;
    for (int i = 0; i <= DEPTH; i++) begin
      LD_VALID = (i < DEPTH);
      LD_DATA  = DATA_W'(16'hA000 + i);
      LD_LAST  = (i == DEPTH-1);
      @(negedge CLK);
      if (i > 0) begin
        total++;
        if ({BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI} !== {1'b1, 1'b1, ADDR_W'(i-1), ref_w[i-1]}) begin
          bad++; $display("FAIL load_write%0d: got en=%b we=%b addr=%0d di=%h expected 1 1 %0d %h",
                          i-1, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI, i-1, ref_w[i-1]);
        end
      end
      @(posedge CLK); #1;
    end
    LD_VALID = 1'b0;
    LD_LAST  = 1'b0;
    W_READY  = 1'b1;
    start_pulse();
    @(negedge CLK);
    total++;
    if ({LD_READY, BRAM_WE} !== 2'b00) begin
      bad++; $display("FAIL ld_ready_busy: got ready=%b we=%b expected 0 0", LD_READY, BRAM_WE);
    end
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge CLK);
      total++;
      if ({W_VALID, W_DATA, W_INDEX} !== {1'b1, ref_w[k], ADDR_W'(k)}) begin
        bad++; $display("FAIL loaded_word%0d: got v=%b d=%h i=%0d expected 1 %h %0d", k, W_VALID, W_DATA, W_INDEX, ref_w[k], k);
      end
    end
    repeat (3) @(posedge CLK);
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_random_ready(1'b0);
    test_backpressure();
    test_start_ignored();
    test_reset_midstream();
`ifdef WEIGHT_STREAM_LOAD_EN
    test_load();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
